// File: rtl/cipher_cfg_regfile.sv
// Purpose: cipher select + double-buffered key register file with sticky LOCK and error counter.
// Latency: access sampled at edge N completes (done/error/rdata) during cycle N+1.
// Backpressure: none; one access accepted every cycle, done pulses once per access.
module cipher_cfg_regfile #(
    parameter int ADDR_WIDTH = 8,
    parameter int REG_WIDTH  = 16,
    parameter int NUM_KEYS   = 3,
    parameter int SEL_WIDTH  = 2,
    parameter int KEY_BASE   = 'h10,
    parameter int KEY_STRIDE = 2
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [ADDR_WIDTH-1:0]         addr,
    input  logic                          read,
    input  logic                          write,
    input  logic [REG_WIDTH-1:0]          wdata,
    output logic [REG_WIDTH-1:0]          rdata,
    output logic                          done,
    output logic                          error,
    output logic [REG_WIDTH-1:0]          select,
    output logic [NUM_KEYS*REG_WIDTH-1:0] keys
);

    logic [SEL_WIDTH-1:0] sel_q;
    logic [REG_WIDTH-1:0] shadow_q [NUM_KEYS];
    logic [REG_WIDTH-1:0] active_q [NUM_KEYS];
    logic                 lock_q;
    logic                 pend_q;
    logic [7:0]           errcnt_q;
    logic                 done_q;
    logic                 error_q;
    logic [REG_WIDTH-1:0] rdata_q;

    logic [31:0]          addr_ext;
    logic                 hit_sel, hit_ctrl, hit_stat, hit_shadow, hit_active;
    logic [NUM_KEYS-1:0]  shadow_oh;
    logic [REG_WIDTH-1:0] key_rd;
    logic                 acc, acc_err, wr_ok, rd_ok;
    logic [REG_WIDTH-1:0] rd_val;

    // Address decode: fixed control registers plus interleaved shadow/active key pairs.
    always_comb begin
        addr_ext   = 32'(addr);
        hit_sel    = (addr_ext == 32'd0);
        hit_ctrl   = (addr_ext == 32'd1);
        hit_stat   = (addr_ext == 32'd2);
        shadow_oh  = '0;
        hit_active = 1'b0;
        key_rd     = '0;
        for (int k = 0; k < NUM_KEYS; k++) begin
            if (addr_ext == 32'(KEY_BASE + k * KEY_STRIDE)) begin
                shadow_oh[k] = 1'b1;
                key_rd       = shadow_q[k];
            end
            if (addr_ext == 32'(KEY_BASE + k * KEY_STRIDE + 1)) begin
                hit_active = 1'b1;
                key_rd     = active_q[k];
            end
        end
        hit_shadow = |shadow_oh;
    end

    // Access classification: any rejected access leaves state untouched apart from ERRCNT.
    always_comb begin
        acc     = read | write;
        acc_err = acc && (!(hit_sel | hit_ctrl | hit_stat | hit_shadow | hit_active)
                          || (read && write)
                          || (write && hit_active)
                          || (write && lock_q));
        wr_ok   = write && !acc_err;
        rd_ok   = read && !acc_err;
    end

    // Read mux; CTRL reads back only the LOCK bit, COMMIT is write-only.
    always_comb begin
        rd_val = '0;
        if (hit_sel) begin
            rd_val[SEL_WIDTH-1:0] = sel_q;
        end else if (hit_ctrl) begin
            rd_val[1] = lock_q;
        end else if (hit_stat) begin
            rd_val[0]    = pend_q;
            rd_val[1]    = lock_q;
            rd_val[15:8] = errcnt_q;
        end else begin
            rd_val = key_rd;
        end
    end

    // State and response registers; an access coinciding with reset is dropped.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sel_q    <= '0;
            lock_q   <= 1'b0;
            pend_q   <= 1'b0;
            errcnt_q <= '0;
            done_q   <= 1'b0;
            error_q  <= 1'b0;
            rdata_q  <= '0;
            for (int k = 0; k < NUM_KEYS; k++) begin
                shadow_q[k] <= '0;
                active_q[k] <= '0;
            end
        end else begin
            done_q  <= acc;
            error_q <= acc_err;
            rdata_q <= rd_ok ? rd_val : '0;
            if (acc_err && (errcnt_q != 8'hFF)) begin
                errcnt_q <= errcnt_q + 8'd1;
            end
            if (wr_ok) begin
                if (hit_sel) begin
                    sel_q <= wdata[SEL_WIDTH-1:0];
                end
                if (hit_ctrl) begin
                    if (wdata[0]) begin
                        for (int k = 0; k < NUM_KEYS; k++) begin
                            active_q[k] <= shadow_q[k];
                        end
                        pend_q <= 1'b0;
                    end
                    if (wdata[1]) begin
                        lock_q <= 1'b1;
                    end
                end
                if (hit_stat) begin
                    errcnt_q <= '0;
                end
                for (int k = 0; k < NUM_KEYS; k++) begin
                    if (shadow_oh[k]) begin
                        shadow_q[k] <= wdata;
                        pend_q      <= 1'b1;
                    end
                end
            end
        end
    end

    // Output packing: response registers and zero-extended select / active key bus.
    always_comb begin
        rdata                  = rdata_q;
        done                   = done_q;
        error                  = error_q;
        select                 = '0;
        select[SEL_WIDTH-1:0]  = sel_q;
        keys                   = '0;
        for (int k = 0; k < NUM_KEYS; k++) begin
            keys[k*REG_WIDTH +: REG_WIDTH] = active_q[k];
        end
    end

endmodule

// File: tb/tb_cipher_cfg_regfile.sv
// Testbench for cipher_cfg_regfile: directed scenarios plus randomized accesses
// compared against a register-map level reference model.
module tb_cipher_cfg_regfile;
    localparam int AW = 8;
    localparam int RW = 16;
    localparam int NK = 3;
    localparam int SW = 2;
    localparam int KB = 'h10;
    localparam int KS = 2;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [AW-1:0] addr = '0;
    logic          read = 1'b0;
    logic          write = 1'b0;
    logic [RW-1:0] wdata = '0;
    logic [RW-1:0] rdata;
    logic          done;
    logic          error;
    logic [RW-1:0] select;
    logic [NK*RW-1:0] keys;

    int passed = 0;
    int total  = 0;

    // reference model state
    logic [SW-1:0] m_sel;
    logic [RW-1:0] m_shadow [NK];
    logic [RW-1:0] m_active [NK];
    bit            m_lock, m_pend;
    int            m_err;
    logic          exp_done, exp_err;
    logic [RW-1:0] exp_rdata, exp_mask;

    cipher_cfg_regfile #(
        .ADDR_WIDTH(AW), .REG_WIDTH(RW), .NUM_KEYS(NK),
        .SEL_WIDTH(SW), .KEY_BASE(KB), .KEY_STRIDE(KS)
    ) dut (
        .clk(clk), .rst_n(rst_n), .addr(addr), .read(read), .write(write),
        .wdata(wdata), .rdata(rdata), .done(done), .error(error),
        .select(select), .keys(keys)
    );

    always #5 clk = ~clk;

    function automatic logic [NK*RW-1:0] exp_keys();
        logic [NK*RW-1:0] v;
        for (int k = 0; k < NK; k++) v[k*RW +: RW] = m_active[k];
        return v;
    endfunction

    function automatic logic [RW-1:0] exp_select();
        return RW'(m_sel);
    endfunction

    task automatic model_reset();
        m_sel = '0; m_lock = 0; m_pend = 0; m_err = 0;
        for (int k = 0; k < NK; k++) begin m_shadow[k] = '0; m_active[k] = '0; end
    endtask

    // Predicts the response of one access and applies its effect to the model.
    task automatic model(input logic rd, input logic wr, input logic [AW-1:0] a, input logic [RW-1:0] wd);
        int off, k;
        bit is_sh, is_act, mapped;
        exp_done = rd | wr; exp_err = 0; exp_rdata = '0; exp_mask = '1;
        if (!(rd | wr)) return;
        off = int'(a) - KB; k = 0; is_sh = 0; is_act = 0;
        if (off >= 0 && off < NK * KS) begin
            k = off / KS;
            is_sh  = (off % KS) == 0;
            is_act = (off % KS) == 1;
        end
        mapped = (a <= 2) || is_sh || is_act;
        if (!mapped || (rd && wr) || (wr && is_act) || (wr && m_lock)) begin
            exp_err = 1;
            if (m_err < 255) m_err++;
            return;
        end
        if (rd) begin
            if (a == 0)       exp_rdata = RW'(m_sel);
            else if (a == 1)  exp_rdata = m_lock ? 16'h0002 : 16'h0000;
            else if (a == 2)  exp_rdata = RW'(m_err * 256 + (m_lock ? 2 : 0) + (m_pend ? 1 : 0));
            else if (is_sh)   exp_rdata = m_shadow[k];
            else              exp_rdata = m_active[k];
        end else begin
            exp_mask = '0;
            if (a == 0) m_sel = wd[SW-1:0];
            else if (a == 1) begin
                if (wd[0]) begin
                    for (int j = 0; j < NK; j++) m_active[j] = m_shadow[j];
                    m_pend = 0;
                end
                if (wd[1]) m_lock = 1;
            end
            else if (a == 2) m_err = 0;
            else begin m_shadow[k] = wd; m_pend = 1; end
        end
    endtask

    // Drives one access for one edge; outputs are then stable for sampling.
    task automatic acc(input logic rd, input logic wr, input logic [AW-1:0] a, input logic [RW-1:0] wd);
        read = rd; write = wr; addr = a; wdata = wd;
        model(rd, wr, a, wd);
        @(posedge clk); #1;
        read = 0; write = 0;
    endtask

    task automatic test_reset();
        logic [AW-1:0] tbl [8];
        tbl = '{8'h00, 8'h02, 8'h10, 8'h11, 8'h12, 8'h13, 8'h14, 8'h15};
        total++;
        if ({done, error, rdata, select, keys} !== '0)
            $display("FAIL reset_outputs: got done=%b err=%b rdata=%h sel=%h keys=%h, want all 0", done, error, rdata, select, keys);
        else passed++;
        for (int i = 0; i < 8; i++) begin
            acc(1, 0, tbl[i], '0);
            total++;
            if ({done, error, rdata} !== {1'b1, 1'b0, 16'h0000})
                $display("FAIL reset_read_%h: got done=%b err=%b rdata=%h, want 1 0 0000", tbl[i], done, error, rdata);
            else passed++;
        end
        @(posedge clk); #1;
        total++;
        if ({done, error, rdata, keys} !== '0)
            $display("FAIL idle_no_done: got done=%b err=%b rdata=%h keys=%h, want 0", done, error, rdata, keys);
        else passed++;
    endtask

    task automatic test_commit();
        acc(0, 1, 8'h12, 16'hBEEF);
        total++;
        if (keys !== '0) $display("FAIL shadow_no_effect: got keys=%h want 0", keys); else passed++;
        acc(1, 0, 8'h02, '0);
        total++;
        if (rdata !== 16'h0001) $display("FAIL status_pending: got %h want 0001", rdata); else passed++;
        acc(0, 1, 8'h01, 16'h0001);
        total++;
        if (keys[31:16] !== 16'hBEEF) $display("FAIL commit_key1: got %h want BEEF", keys[31:16]); else passed++;
        acc(1, 0, 8'h02, '0);
        total++;
        if (rdata !== 16'h0000) $display("FAIL status_cleared: got %h want 0000", rdata); else passed++;
        acc(1, 0, 8'h13, '0);
        total++;
        if (rdata !== 16'hBEEF) $display("FAIL read_active1: got %h want BEEF", rdata); else passed++;
    endtask

    task automatic test_select();
        acc(0, 1, 8'h00, 16'hFFFF);
        total++;
        if (select !== 16'h0003) $display("FAIL select_mask: got %h want 0003", select); else passed++;
        acc(1, 0, 8'h00, '0);
        total++;
        if (rdata !== 16'h0003) $display("FAIL select_read: got %h want 0003", rdata); else passed++;
    endtask

    task automatic test_errors();
        acc(1, 0, 8'hFF, '0);
        total++;
        if ({done, error, rdata} !== {1'b1, 1'b1, 16'h0}) $display("FAIL err_unmapped: got done=%b err=%b rdata=%h want 1 1 0", done, error, rdata); else passed++;
        acc(0, 1, 8'h13, 16'h5555);
        total++;
        if ({error, keys[31:16]} !== {1'b1, 16'hBEEF}) $display("FAIL err_active_wr: got err=%b key1=%h want 1 BEEF", error, keys[31:16]); else passed++;
        acc(1, 1, 8'h00, 16'h0000);
        total++;
        if ({error, select} !== {1'b1, 16'h0003}) $display("FAIL err_rw_both: got err=%b sel=%h want 1 0003", error, select); else passed++;
        acc(1, 0, 8'h02, '0);
        total++;
        if (rdata[15:8] !== 8'd3) $display("FAIL errcnt_3: got %h want 03", rdata[15:8]); else passed++;
        acc(0, 1, 8'h02, 16'h0000);
        acc(1, 0, 8'h02, '0);
        total++;
        if (rdata[15:8] !== 8'd0) $display("FAIL errcnt_clear: got %h want 00", rdata[15:8]); else passed++;
    endtask

    task automatic test_back_to_back();
        logic [RW-1:0] v;
        v = RW'($urandom);
        acc(0, 1, 8'h14, v);
        acc(1, 0, 8'h14, '0);
        total++;
        if ({done, error, rdata} !== {1'b1, 1'b0, v}) $display("FAIL b2b_readback: got done=%b err=%b rdata=%h want 1 0 %h", done, error, rdata, v); else passed++;
        acc(1, 0, 8'h00, '0);
        total++;
        if ({done, rdata} !== {1'b1, 16'h0003}) $display("FAIL b2b_done_held: got done=%b rdata=%h want 1 0003", done, rdata); else passed++;
    endtask

    task automatic test_random();
        logic [AW-1:0] tbl [13];
        logic [AW-1:0] a;
        logic [RW-1:0] wd;
        int kind;
        tbl = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h0F, 8'h10, 8'h11, 8'h12, 8'h13, 8'h14, 8'h15, 8'h16, 8'hFF};
        for (int i = 0; i < 400; i++) begin
            a = tbl[$urandom_range(0, 12)];
            wd = RW'($urandom);
            if (a == 8'h01) wd[1] = 1'b0;
            kind = $urandom_range(0, 9);
            if (kind == 0)      acc(0, 0, a, wd);
            else if (kind == 1) acc(1, 1, a, wd);
            else if (kind < 6)  acc(1, 0, a, wd);
            else                acc(0, 1, a, wd);
            total++;
            if ({done, error, rdata & exp_mask} !== {exp_done, exp_err, exp_rdata})
                $display("FAIL rand_resp[%0d] a=%h: got done=%b err=%b rdata=%h want %b %b %h", i, a, done, error, rdata & exp_mask, exp_done, exp_err, exp_rdata);
            else passed++;
            total++;
            if ({select, keys} !== {exp_select(), exp_keys()})
                $display("FAIL rand_state[%0d]: got sel=%h keys=%h want sel=%h keys=%h", i, select, keys, exp_select(), exp_keys());
            else passed++;
        end
    endtask

    task automatic test_lock();
        acc(0, 1, 8'h10, 16'h1234);
        acc(0, 1, 8'h01, 16'h0003);
        total++;
        if ({error, keys[15:0]} !== {1'b0, 16'h1234}) $display("FAIL lock_commit: got err=%b key0=%h want 0 1234", error, keys[15:0]); else passed++;
        total++;
        if (keys !== exp_keys()) $display("FAIL lock_keys: got %h want %h", keys, exp_keys()); else passed++;
        acc(1, 0, 8'h02, '0);
        total++;
        if (rdata[1:0] !== 2'b10) $display("FAIL lock_status: got %b want 10", rdata[1:0]); else passed++;
        acc(0, 1, 8'h00, 16'h0001);
        total++;
        if ({error, select} !== {1'b1, exp_select()}) $display("FAIL lock_select: got err=%b sel=%h want 1 %h", error, select, exp_select()); else passed++;
        for (int i = 0; i < 260; i++) acc(1, 0, 8'hFF, '0);
        acc(1, 0, 8'h02, '0);
        total++;
        if (rdata[15:8] !== 8'hFF) $display("FAIL errcnt_sat: got %h want FF", rdata[15:8]); else passed++;
        acc(0, 1, 8'h02, 16'h0000);
        total++;
        if (error !== 1'b1) $display("FAIL lock_status_wr: got err=%b want 1", error); else passed++;
        acc(1, 0, 8'h02, '0);
        total++;
        if (rdata !== 16'hFF02) $display("FAIL errcnt_noclr: got %h want FF02", rdata); else passed++;
    endtask

    task automatic test_reset_mid();
        acc(1, 0, 8'h02, '0);
        acc(0, 1, 8'h00, 16'h0002);
        rst_n = 0; read = 1; addr = 8'h00;
        @(posedge clk); #1;
        read = 0; rst_n = 1;
        model_reset();
        total++;
        if ({done, error, rdata, select, keys} !== '0)
            $display("FAIL mid_reset: got done=%b err=%b rdata=%h sel=%h keys=%h want all 0", done, error, rdata, select, keys);
        else passed++;
        acc(1, 0, 8'h02, '0);
        total++;
        if ({done, error, rdata} !== {1'b1, 1'b0, 16'h0000}) $display("FAIL post_reset_status: got done=%b err=%b rdata=%h want 1 0 0000", done, error, rdata); else passed++;
        acc(0, 1, 8'h00, 16'h0002);
        total++;
        if ({error, select} !== {1'b0, 16'h0002}) $display("FAIL post_reset_write: got err=%b sel=%h want 0 0002", error, select); else passed++;
    endtask

    initial begin
        model_reset();
        repeat (3) @(posedge clk);
        #1 rst_n = 1;
        test_reset();
        test_commit();
        test_select();
        test_errors();
        test_back_to_back();
        test_random();
        test_lock();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/cipher_cfg_regfile.md
# cipher_cfg_regfile

Parametrised configuration register file for the decryption datapath, successor to the fixed three-key regfile. It exposes a cipher select register plus NUM_KEYS keys behind an addressed read/write port with one-cycle done/error handshake. Keys are double-buffered: software writes shadow copies and an atomic COMMIT transfers them to the active key outputs, so ciphers never see a half-updated key set. A sticky LOCK and a saturating error counter support secure bring-up and diagnostics.

## Interface
- ADDR_WIDTH, 8, address bus width
- REG_WIDTH, 16, data and key width (must be >= 16)
- NUM_KEYS, 3, number of key channels (1..8)
- SEL_WIDTH, 2, implemented bits of SELECT
- KEY_BASE, 'h10, address of shadow key 0
- KEY_STRIDE, 2, address distance between consecutive keys (>= 2)

- clk  input  1  single clock, all logic on rising edge
- rst_n  input  1  reset, synchronous, active-low
- addr  input  ADDR_WIDTH  access address, sampled with read/write
- read  input  1  read request, sampled at rising edge
- write  input  1  write request, sampled at rising edge
- wdata  input  REG_WIDTH  write data
- rdata  output  REG_WIDTH  read data, valid only while done=1
- done  output  1  one-cycle access completion pulse
- error  output  1  valid only while done=1; access rejected
- select  output  REG_WIDTH  cipher select, bits above SEL_WIDTH are 0
- keys  output  NUM_KEYS*REG_WIDTH  active keys, key k at [k*REG_WIDTH +: REG_WIDTH]

## Operation
- Register map:
  - 0x00 SELECT RW, low SEL_WIDTH bits stored, rest read 0
  - 0x01 CTRL: write bit0=1 -> COMMIT (reads 0); bit1 LOCK, sticky, write-1-to-set only; read returns {.., LOCK, 0}
  - 0x02 STATUS: bit0 PENDING, bit1 LOCK, bits[15:8] ERRCNT; any write clears ERRCNT
  - KEY_BASE+k*KEY_STRIDE: shadow key k, RW
  - KEY_BASE+k*KEY_STRIDE+1: active key k, RO
- Error conditions (no state change, rdata=0, error=1): unmapped address; read and write both high; write to an active-key address; any write while LOCK=1.
- COMMIT: all active keys <= shadow keys in one edge; PENDING cleared. Shadow key write sets PENDING.
- COMMIT and LOCK in the same CTRL write: commit applies and lock sets at that edge.
- Shadow write and COMMIT cannot coincide (one access per cycle).
- ERRCNT increments by 1 per errored access, saturates at 255; STATUS write while LOCK=1 is itself an error (counts, no clear).
- SELECT writes take effect immediately (not shadowed).
- LOCK clears only on reset.

## Timing
- Reset (rst_n=0 at rising edge): select, all shadow and active keys, LOCK, PENDING, ERRCNT = 0; done=0, error=0, rdata=0. An access sampled at the same edge as reset is discarded, no done.
- Access sampled at edge N -> done=1 (error, rdata valid) during cycle N+1, exactly one cycle; done=0 otherwise, rdata=0 and error=0 when done=0.
- Register updates (select, shadow, active, LOCK, ERRCNT) visible on outputs/reads from edge N+1.
- Back-to-back accesses every cycle accepted; done may stay high across consecutive cycles, one pulse-cycle per access.
- Read of a register being written at the previous edge returns the new value.
- read=write=0: no done, no state change.

## Test plan
- Reset then read 0x00, 0x02, each shadow/active key -> done one cycle later, rdata=0, error=0; keys bus all 0.
- Write shadow key 1 = 0xBEEF -> keys unchanged, STATUS=0x0001; write CTRL=0x0001 -> keys[31:16]=0xBEEF one cycle after, STATUS=0x0000, read active key 1 = 0xBEEF.
- Write 0x00=0xFFFF -> select=0x0003, read 0x00 returns 0x0003.
- Read unmapped 0xFF, write active-key address, read+write simultaneous -> error=1 each, STATUS bits[15:8]=3; write STATUS -> ERRCNT=0.
- Write CTRL=0x0003 with pending shadow 0x1234 on key 0 -> keys committed, LOCK=1; then write SELECT=1 -> error=1, select stays; 260 errored accesses -> ERRCNT=255.
- Assert rst_n=0 mid back-to-back sequence with LOCK=1 -> next cycle all outputs 0, LOCK=0, no done for discarded access; writes accepted again.
